// File: rtl/shifter_pkg.sv
// Types and constants shared by the transmit- and receive-side shifters.
package shifter_pkg;
  typedef enum logic {PISO_IDLE = 1'b0, PISO_SHIFT = 1'b1} piso_state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;
endpackage

// File: rtl/piso_bit_counter.sv
// Bits-remaining counter for one frame: loads N on accept, counts down per enabled shift.
// last flags the final bit of the frame.
module piso_bit_counter #(
  parameter int N = 32
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic active,
  output logic last
);
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;

  // A reload on the last-bit cycle takes priority over the decrement.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(N);
    end else if (active && en) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == CW'(1));
endmodule

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter: accepts an N-bit word and emits it one bit per enabled cycle.
// First bit valid the cycle after accept; load_ready re-opens on the last-bit cycle for gapless frames.
module piso_shift
  import shifter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         dir,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_data,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);
  piso_state_t  state;
  piso_state_t  state_nxt;
  logic [N-1:0] sreg;
  logic         dir_q;
  logic         last;
  logic         accept;

  assign accept = load_valid && load_ready;

  piso_bit_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .clr   (clr),
    .load  (accept),
    .en    (en),
    .active(busy),
    .last  (last)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= PISO_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PISO_IDLE: begin
        if (accept) state_nxt = PISO_SHIFT;
      end
      PISO_SHIFT: begin
        if (en && last) state_nxt = accept ? PISO_SHIFT : PISO_IDLE;
      end
      default: state_nxt = PISO_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == PISO_SHIFT);
    sout_valid = busy && en;
    load_ready = !busy || (en && last);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sreg  <= '0;
      dir_q <= DIR_LSB_FIRST;
      done  <= 1'b0;
    end else begin
      done <= sout_valid && last;
      if (accept) begin
        sreg  <= load_data;
        dir_q <= dir;
      end else if (sout_valid) begin
        sreg <= (dir_q == DIR_MSB_FIRST) ? {sreg[N-2:0], 1'b0} : {1'b0, sreg[N-1:1]};
      end
    end
  end

  // Zero-fill means an idle register always presents 0 on the serial line.
  assign sout = (dir_q == DIR_MSB_FIRST) ? sreg[N-1] : sreg[0];
endmodule

// File: tb/tb_piso_shift.sv
// Bench for piso_shift at N = 8: spec vectors, hand-written corner sequences, random vs. a queue model.
module tb_piso_shift;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         clr, en, dir, load_valid;
  logic [N-1:0] load_data;
  logic         load_ready, sout, sout_valid, busy, done;

  int tests = 0;
  int fails = 0;

  // Reference model: the bits still to be sent, in wire order, plus the pending done pulse.
  bit q[$];
  bit mdone;

  // Outputs captured at the most recent sample point.
  logic s_sout, s_sv, s_busy, s_done, s_lr;

  piso_shift #(.N(N)) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .dir       (dir),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .sout      (sout),
    .sout_valid(sout_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, en, dir, lv;
    logic [7:0] ld;
    logic       sout, sv, busy, done, lr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic c, e, d, lv, input logic [7:0] ld,
                     input logic so, sv, b, dn, lr);
    vec_t v;
    v.clr = c; v.en = e; v.dir = d; v.lv = lv; v.ld = ld;
    v.sout = so; v.sv = sv; v.busy = b; v.done = dn; v.lr = lr;
    vecs.push_back(v);
  endtask

  // One clock cycle: drive just after the rising edge, sample on the falling edge,
  // check against the model, then advance the model across the next rising edge.
  task automatic cyc(input logic c, e, d, lv, input logic [N-1:0] ld);
    logic busy_e, lr_e, sv_e, sout_e;
    @(posedge clk);
    #1;
    clr = c; en = e; dir = d; load_valid = lv; load_data = ld;
    #4;
    s_sout = sout; s_sv = sout_valid; s_busy = busy; s_done = done; s_lr = load_ready;
    if (!c) begin
      q.delete();
      mdone = 1'b0;
      chk("mdl_rst_sout", s_sout, 1'b0);
      chk("mdl_rst_sv", s_sv, 1'b0);
      chk("mdl_rst_busy", s_busy, 1'b0);
      chk("mdl_rst_done", s_done, 1'b0);
      chk("mdl_rst_lr", s_lr, 1'b1);
    end else begin
      busy_e = (q.size() != 0);
      lr_e   = !busy_e || (e && q.size() == 1);
      sv_e   = busy_e && e;
      sout_e = busy_e ? q[0] : 1'b0;
      chk("mdl_sout", s_sout, sout_e);
      chk("mdl_sv", s_sv, sv_e);
      chk("mdl_busy", s_busy, busy_e);
      chk("mdl_done", s_done, mdone);
      chk("mdl_lr", s_lr, lr_e);
      mdone = sv_e && (q.size() == 1);
      if (sv_e) void'(q.pop_front());
      if (lv && lr_e) begin
        for (int i = 0; i < N; i++) q.push_back(ld[d ? (N - 1 - i) : i]);
      end
    end
  endtask

  initial begin
    int lsb_bits[8] = '{0, 0, 1, 0, 1, 1, 0, 1};
    int msb_bits[8] = '{1, 0, 1, 1, 0, 1, 0, 0};
    int b2b_bits[16] = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int bp_bits[8] = '{1, 1, 0, 0, 0, 0, 1, 1};
    int stall_bits[14] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1};

    clr = 1'b0; en = 1'b0; dir = 1'b0; load_valid = 1'b0; load_data = '0;
    mdone = 1'b0;

    // Reset state.
    add(0, 1, 0, 1, 8'hAA, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 1);
    // LSB-first 0xB4: accept on cycle 0, bits on 1..8, done on 9.
    add(1, 1, 0, 1, 8'hB4, 0, 0, 0, 0, 1);
    for (int c = 1; c <= 8; c++)
      add(1, 1, 0, 0, 8'h00, 1'(lsb_bits[c-1]), 1, 1, 0, (c == 8));
    add(1, 1, 0, 0, 8'h00, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 1);
    // MSB-first 0xB4 with dir toggling mid-frame.
    add(1, 1, 1, 1, 8'hB4, 0, 0, 0, 0, 1);
    for (int c = 1; c <= 8; c++)
      add(1, 1, 1'(c % 2), 0, 8'h00, 1'(msb_bits[c-1]), 1, 1, 0, (c == 8));
    add(1, 1, 0, 0, 8'h00, 0, 0, 0, 1, 1);
    // Stall: en low on cycles 3..5, done moves from cycle 9 to 12.
    add(1, 1, 0, 1, 8'hB4, 0, 0, 0, 0, 1);
    for (int c = 1; c <= 11; c++) begin
      if (c >= 3 && c <= 5)
        add(1, 0, 0, 0, 8'h00, 1'(stall_bits[c-1]), 0, 1, 0, 0);
      else
        add(1, 1, 0, 0, 8'h00, 1'(stall_bits[c-1]), 1, 1, 0, (c == 11));
    end
    add(1, 1, 0, 0, 8'h00, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      cyc(vecs[i].clr, vecs[i].en, vecs[i].dir, vecs[i].lv, vecs[i].ld);
      chk("tbl_sout", s_sout, vecs[i].sout);
      chk("tbl_sout_valid", s_sv, vecs[i].sv);
      chk("tbl_busy", s_busy, vecs[i].busy);
      chk("tbl_done", s_done, vecs[i].done);
      chk("tbl_load_ready", s_lr, vecs[i].lr);
    end

    // Reset mid-frame: load offered during reset is dropped, no done pulse follows.
    cyc(1, 1, 0, 1, 8'hB4);
    cyc(1, 1, 0, 0, 8'h00);
    cyc(1, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 1, 8'hFF);
    chk("rst_mid_sout", s_sout, 1'b0);
    chk("rst_mid_sv", s_sv, 1'b0);
    chk("rst_mid_busy", s_busy, 1'b0);
    chk("rst_mid_done", s_done, 1'b0);
    chk("rst_mid_lr", s_lr, 1'b1);
    cyc(1, 1, 0, 0, 8'h00);
    chk("rst_after_busy", s_busy, 1'b0);
    chk("rst_after_done", s_done, 1'b0);
    cyc(1, 1, 0, 1, 8'h0F);
    for (int c = 1; c <= 9; c++) begin
      cyc(1, 1, 0, 0, 8'h00);
      if (c <= 8) chk("rst_clean_sout", s_sout, (c <= 4));
      chk("rst_clean_done", s_done, (c == 9));
    end

    // Back-to-back: 0xB4 then 0x0F with load_valid held high.
    cyc(1, 1, 0, 1, 8'hB4);
    for (int c = 1; c <= 16; c++) begin
      cyc(1, 1, 0, (c <= 8), 8'h0F);
      chk("b2b_sout", s_sout, 1'(b2b_bits[c-1]));
      chk("b2b_sv", s_sv, 1'b1);
      chk("b2b_done", s_done, (c == 9));
      if (c <= 15) chk("b2b_lr", s_lr, (c == 8));
    end
    cyc(1, 1, 0, 0, 8'h00);
    chk("b2b_done17", s_done, 1'b1);
    chk("b2b_busy17", s_busy, 1'b0);

    // Backpressure: words offered early are ignored; the cycle-8 value is captured.
    cyc(1, 1, 0, 1, 8'hB4);
    for (int c = 1; c <= 8; c++) begin
      cyc(1, 1, 0, 1, (c == 8) ? 8'hC3 : 8'(8'h50 + c));
      chk("bp_lr", s_lr, (c == 8));
    end
    for (int c = 9; c <= 16; c++) begin
      cyc(1, 1, 0, 0, 8'h00);
      chk("bp_sout", s_sout, 1'(bp_bits[c-9]));
    end
    cyc(1, 1, 0, 0, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
          1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
